// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO between instruction fetch and decode.
// Each entry pairs a PC with its instruction word. There is no empty-queue
// bypass, so a push is visible on the output one cycle later. A flush (taken
// branch) empties the queue and takes priority over a same-cycle push or pop.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic push;
    logic pop;

    // Handshake qualification; flush and reset suppress both transfers.
    // Accepting only when not full (independent of out_ready) means there is
    // no push-through on a full queue.
    always_comb begin
        in_ready  = !rst && (count_reg < DEPTH_C);
        out_valid = !rst && (count_reg != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush && !rst;
        out_pc    = out_valid ? pc_mem[head_reg]    : '0;
        out_instr = out_valid ? instr_mem[head_reg] : '0;
        count     = count_reg;
    end

    // Entry storage: written at the tail on push, never cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_reg]    <= in_pc;
            instr_mem[tail_reg] <= in_instr;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule
